// File: rtl/uart_pkg.sv
// Shared UART arbitration types, default word width and the rotating-priority pick.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  localparam int BITS_PER_WORD_DEF = 8;
  localparam int MAX_REQ           = 16;
  localparam int IDX_MAX_W         = 4;

  // First requesting index after `last`, wrapping modulo n (n <= MAX_REQ).
  function automatic logic [IDX_MAX_W-1:0] rr_pick(input logic [MAX_REQ-1:0]   req,
                                                   input logic [IDX_MAX_W-1:0] last,
                                                   input int                   n);
    logic [IDX_MAX_W-1:0] pick;
    logic                 found;
    int                   idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      idx = (int'(last) + k) % n;
      if (k <= n && !found && req[idx[IDX_MAX_W-1:0]]) begin
        pick  = idx[IDX_MAX_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_priority_sel.sv
// Combinational rotating-priority encoder: lowest requester index at or after last+1, with wrap.
module rr_priority_sel
  import uart_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  logic [MAX_REQ-1:0]   req_pad;
  logic [IDX_MAX_W-1:0] last_pad;

  always_comb begin
    req_pad                 = '0;
    req_pad[N_REQ-1:0]      = req;
    last_pad                = '0;
    last_pad[IDX_W-1:0]     = last;
    gnt_idx                 = IDX_W'(rr_pick(req_pad, last_pad, N_REQ));
    any                     = |req;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-atomic sharing of one UART TX serializer among N_REQ byte streams.
// Define UART_ARB_ID_HDR_EN to prefix every packet with a requester-index header byte.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int N_REQ         = 4,
  parameter  int BITS_PER_WORD = BITS_PER_WORD_DEF,
  localparam int IDX_W         = $clog2(N_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_REQ-1:0]               s_valid,
  input  logic [N_REQ*BITS_PER_WORD-1:0] s_data,
  input  logic [N_REQ-1:0]               s_last,
  output logic [N_REQ-1:0]               s_ready,
  output logic                           m_valid,
  output logic [BITS_PER_WORD-1:0]       m_data,
  input  logic                           m_ready,
  output logic                           busy,
  output logic [IDX_W-1:0]               grant_id
);

  arb_state_t               state, state_nxt;
  logic [IDX_W-1:0]         last_grant;
  logic [IDX_W-1:0]         pick_idx;
  logic                     pick_any;
  logic                     sel_valid;
  logic                     sel_last;
  logic [BITS_PER_WORD-1:0] sel_data;

  rr_priority_sel #(.N_REQ(N_REQ)) u_sel (
    .req     (s_valid),
    .last    (last_grant),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // last_grant resets to N_REQ-1 so requester 0 holds top priority first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= IDX_W'(N_REQ - 1);
      grant_id   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && pick_any) begin
        grant_id   <= pick_idx;
        last_grant <= pick_idx;
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id == IDX_W'(i)) begin
        sel_valid = s_valid[i];
        sel_last  = s_last[i];
        sel_data  = s_data[i*BITS_PER_WORD +: BITS_PER_WORD];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pick_any) begin
`ifdef UART_ARB_ID_HDR_EN
          state_nxt = HDR;
`else
          state_nxt = DATA;
`endif
        end
      end
`ifdef UART_ARB_ID_HDR_EN
      HDR: begin
        if (m_ready) state_nxt = DATA;
      end
`endif
      DATA: begin
        if (sel_valid && m_ready && sel_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Data path is a pure pass-through of the owner; m_valid never looks at m_ready.
  always_comb begin
    m_valid = 1'b0;
    m_data  = '0;
    s_ready = '0;
    busy    = (state != IDLE);
    case (state)
`ifdef UART_ARB_ID_HDR_EN
      HDR: begin
        m_valid = 1'b1;
        m_data  = BITS_PER_WORD'(grant_id);
      end
`endif
      DATA: begin
        m_valid = sel_valid;
        m_data  = sel_data;
        for (int i = 0; i < N_REQ; i++) begin
          s_ready[i] = (grant_id == IDX_W'(i)) && m_ready;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized packets vs a packet-level model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;
`ifdef UART_ARB_ID_HDR_EN
  localparam int HDR_EN = 1;
`else
  localparam int HDR_EN = 0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   s_valid, s_last, s_ready;
  logic [N*W-1:0] s_data;
  logic           m_valid, m_ready, busy;
  logic [W-1:0]   m_data;
  logic [IW-1:0]  grant_id;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .BITS_PER_WORD(W)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .busy(busy), .grant_id(grant_id)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] src_data [N][$];
  bit         src_last [N][$];
  bit         src_en   [N];
  bit         mid      [N];
  logic [7:0] out_q[$];
  int         out_g[$];
  logic [7:0] pay_q[$];
  int         pay_g[$];
  int         pay_c[$];

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      s_valid[i]        = src_en[i] && (src_data[i].size() > 0);
      s_data[i*W +: W]  = (src_data[i].size() > 0) ? src_data[i][0] : 8'h00;
      s_last[i]         = (src_last[i].size() > 0) ? src_last[i][0] : 1'b0;
    end
  endtask

  // Record the handshakes that will complete at the coming edge, then advance one cycle.
  task automatic step();
    int popped;
    bit lst;
    popped = -1;
    for (int i = 0; i < N; i++) begin
      if (s_valid[i] && s_ready[i]) begin
        void'(src_data[i].pop_front());
        lst = src_last[i].pop_front();
        mid[i] = !lst;
        popped = i;
      end
    end
    if (m_valid && m_ready) begin
      out_q.push_back(m_data);
      out_g.push_back(int'(grant_id));
      if (popped >= 0) begin
        pay_q.push_back(m_data);
        pay_g.push_back(popped);
        pay_c.push_back(cyc);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    drive();
    #1;
  endtask

  task automatic push_byte(input int i, input logic [7:0] d, input bit l);
    src_data[i].push_back(d);
    src_last[i].push_back(l);
  endtask

  task automatic push_pkt(input int i, input logic [7:0] base, input int len);
    for (int k = 0; k < len; k++) push_byte(i, base + 8'(k), k == len - 1);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      src_data[i].delete();
      src_last[i].delete();
      src_en[i] = 1'b1;
      mid[i] = 1'b0;
    end
    drive();
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
    drive();
    #1;
    out_q.delete(); out_g.delete(); pay_q.delete(); pay_g.delete(); pay_c.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < N; i++) src_en[i] = 1'b1;
    push_byte(1, 8'h77, 1'b1);
    drive();
    @(posedge clk);
    #1;
    drive();
    #1;
    n_checks++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
    n_checks++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL reset_m_data: got %h expected 00", m_data); end
    n_checks++; if (s_ready !== 4'h0) begin n_fail++; $display("FAIL reset_s_ready: got %b expected 0000", s_ready); end
    n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
  endtask

  task automatic test_basic();
    int t0, nb;
    reset_dut();
    push_pkt(2, 8'h41, 3);
    drive();
    #1;
    t0 = cyc;
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL basic_idle_m_valid: got %b expected 0", m_valid); end
    step();
    nb = 0;
    while (busy === 1'b1 && nb < 20) begin step(); nb++; end
    n_checks++;
    if (pay_q.size() != 3 || out_q.size() != 3 + HDR_EN) begin
      n_fail++; $display("FAIL basic_count: got %0d/%0d expected 3/%0d", pay_q.size(), out_q.size(), 3 + HDR_EN);
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (pay_q[k] !== 8'h41 + 8'(k)) begin n_fail++; $display("FAIL basic_data%0d: got %h expected %h", k, pay_q[k], 8'h41 + 8'(k)); end
      end
      n_checks++; if (out_q[0] !== (HDR_EN != 0 ? 8'h02 : 8'h41)) begin n_fail++; $display("FAIL basic_first_byte: got %h", out_q[0]); end
      n_checks++; if (pay_c[0] != t0 + 1 + HDR_EN) begin n_fail++; $display("FAIL basic_latency: got %0d expected %0d", pay_c[0] - t0, 1 + HDR_EN); end
      n_checks++; if (pay_c[2] != cyc - 1) begin n_fail++; $display("FAIL basic_busy_drop: got %0d expected %0d", cyc, pay_c[2] + 1); end
    end
    n_checks++; if (grant_id !== 2'd2) begin n_fail++; $display("FAIL basic_grant_id: got %0d expected 2", grant_id); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_all_simul();
    int nb;
    int exp_g[5] = '{0, 1, 2, 3, 0};
    logic [7:0] exp_d[5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20};
    reset_dut();
    for (int i = 0; i < N; i++) begin
      push_byte(i, 8'h10 + 8'(i), 1'b1);
      push_byte(i, 8'h20 + 8'(i), 1'b1);
    end
    drive();
    #1;
    nb = 0;
    while (pay_q.size() < 5 && nb < 60) begin step(); nb++; end
    n_checks++;
    if (pay_q.size() < 5) begin
      n_fail++; $display("FAIL simul_timeout: got %0d packets expected 5", pay_q.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_checks++;
        if (pay_g[k] != exp_g[k] || pay_q[k] !== exp_d[k]) begin
          n_fail++; $display("FAIL simul_grant%0d: got req %0d data %h expected req %0d data %h", k, pay_g[k], pay_q[k], exp_g[k], exp_d[k]);
        end
      end
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (pay_c[k+1] - pay_c[k] != 2 + HDR_EN) begin
          n_fail++; $display("FAIL simul_gap%0d: got %0d expected %0d", k, pay_c[k+1] - pay_c[k], 2 + HDR_EN);
        end
      end
    end
  endtask

  task automatic test_mid_packet();
    int nb;
    reset_dut();
    push_pkt(1, 8'hA1, 4);
    drive();
    #1;
    nb = 0;
    while (pay_q.size() < 2 && nb < 20) begin step(); nb++; end
    push_byte(0, 8'hB0, 1'b1);
    drive();
    #1;
    while (src_data[1].size() > 0 && nb < 40) begin
      n_checks++; if (s_ready[0] !== 1'b0) begin n_fail++; $display("FAIL mid_s_ready0: got %b expected 0", s_ready[0]); end
      step(); nb++;
    end
    while (pay_q.size() < 5 && nb < 60) begin step(); nb++; end
    n_checks++;
    if (pay_q.size() != 5) begin
      n_fail++; $display("FAIL mid_count: got %0d expected 5", pay_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (pay_g[k] != 1 || pay_q[k] !== 8'hA1 + 8'(k)) begin n_fail++; $display("FAIL mid_req1_byte%0d: got req %0d data %h", k, pay_g[k], pay_q[k]); end
      end
      n_checks++; if (pay_g[4] != 0 || pay_q[4] !== 8'hB0) begin n_fail++; $display("FAIL mid_req0: got req %0d data %h expected req 0 data b0", pay_g[4], pay_q[4]); end
    end
  endtask

  task automatic test_stall();
    int nb;
    reset_dut();
    push_byte(3, 8'h5A, 1'b0);
    push_byte(3, 8'hA5, 1'b1);
    drive();
    #1;
    nb = 0;
    while (!(m_valid === 1'b1 && m_data === 8'h5A) && nb < 10) begin step(); nb++; end
    m_ready = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (m_valid !== 1'b1 || m_data !== 8'h5A) begin n_fail++; $display("FAIL stall_hold%0d: got v=%b d=%h expected v=1 d=5a", k, m_valid, m_data); end
      step();
    end
    m_ready = 1'b1;
    #1;
    while (busy === 1'b1 && nb < 30) begin step(); nb++; end
    n_checks++;
    if (pay_q.size() != 2) begin
      n_fail++; $display("FAIL stall_count: got %0d expected 2", pay_q.size());
    end else begin
      n_checks++; if (pay_q[0] !== 8'h5A || pay_q[1] !== 8'hA5) begin n_fail++; $display("FAIL stall_data: got %h %h expected 5a a5", pay_q[0], pay_q[1]); end
    end
  endtask

  task automatic test_valid_gap();
    int nb;
    reset_dut();
    push_pkt(1, 8'hC1, 4);
    drive();
    #1;
    nb = 0;
    while (pay_q.size() < 2 && nb < 20) begin step(); nb++; end
    src_en[1] = 1'b0;
    drive();
    #1;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (m_valid !== 1'b0 || busy !== 1'b1 || grant_id !== 2'd1) begin
        n_fail++; $display("FAIL gap_hold%0d: got v=%b busy=%b gid=%0d expected v=0 busy=1 gid=1", k, m_valid, busy, grant_id);
      end
      step();
    end
    src_en[1] = 1'b1;
    drive();
    #1;
    while (busy === 1'b1 && nb < 40) begin step(); nb++; end
    n_checks++;
    if (pay_q.size() != 4) begin
      n_fail++; $display("FAIL gap_count: got %0d expected 4", pay_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (pay_q[k] !== 8'hC1 + 8'(k)) begin n_fail++; $display("FAIL gap_data%0d: got %h expected %h", k, pay_q[k], 8'hC1 + 8'(k)); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int nb;
    reset_dut();
    push_pkt(2, 8'hD1, 4);
    drive();
    #1;
    nb = 0;
    while (pay_q.size() < 1 && nb < 20) begin step(); nb++; end
    rst = 1'b1;
    step();
    rst = 1'b0;
    src_data[2].delete();
    src_last[2].delete();
    mid[2] = 1'b0;
    push_pkt(2, 8'hD1, 4);
    push_byte(0, 8'hE0, 1'b1);
    drive();
    #1;
    n_checks++;
    if (busy !== 1'b0 || m_valid !== 1'b0 || m_data !== 8'h00 || s_ready !== 4'h0 || grant_id !== 2'd0) begin
      n_fail++; $display("FAIL rstmid_outputs: got busy=%b v=%b d=%h rdy=%b gid=%0d expected all 0", busy, m_valid, m_data, s_ready, grant_id);
    end
    step();
    n_checks++;
    if (grant_id !== 2'd0 || busy !== 1'b1 || m_valid !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_regrant: got gid=%0d busy=%b v=%b expected gid=0 busy=1 v=1", grant_id, busy, m_valid);
    end
  endtask

  task automatic test_random();
    logic [7:0] pk_bytes [N][$];
    int         pk_len   [N][$];
    logic [7:0] exp_d[$];
    int         exp_g[$];
    int         npk[N], rem[N], cur[N];
    int         prev, total, w, len, nb, pno;
    logic [7:0] b;
    reset_dut();
    total = 0;
    for (int i = 0; i < N; i++) begin
      npk[i] = $urandom_range(0, 3);
      rem[i] = npk[i];
      cur[i] = 0;
      total += npk[i];
      for (int p = 0; p < npk[i]; p++) begin
        len = $urandom_range(1, 5);
        pk_len[i].push_back(len);
        for (int k = 0; k < len; k++) begin
          b = 8'($urandom);
          pk_bytes[i].push_back(b);
          push_byte(i, b, k == len - 1);
        end
      end
    end
    // Every pending requester is visible at each arbitration, so order follows pending packet counts.
    prev = N - 1;
    for (int p = 0; p < total; p++) begin
      w = -1;
      for (int k = 1; k <= N; k++) begin
        if (w < 0 && rem[(prev + k) % N] > 0) w = (prev + k) % N;
      end
      pno = npk[w] - rem[w];
      if (HDR_EN != 0) begin exp_d.push_back(8'(w)); exp_g.push_back(w); end
      for (int k = 0; k < pk_len[w][pno]; k++) begin
        exp_d.push_back(pk_bytes[w][cur[w] + k]);
        exp_g.push_back(w);
      end
      cur[w] += pk_len[w][pno];
      rem[w]--;
      prev = w;
    end
    nb = 0;
    while ((out_q.size() < exp_d.size() || busy === 1'b1) && nb < 3000) begin
      m_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) src_en[i] = mid[i] ? ($urandom_range(0, 3) != 0) : 1'b1;
      drive();
      #1;
      step();
      nb++;
    end
    n_checks++;
    if (nb >= 3000 || out_q.size() != exp_d.size()) begin
      n_fail++; $display("FAIL rand_count: got %0d bytes expected %0d (cycles %0d)", out_q.size(), exp_d.size(), nb);
    end else begin
      for (int k = 0; k < exp_d.size(); k++) begin
        n_checks++;
        if (out_q[k] !== exp_d[k] || out_g[k] != exp_g[k]) begin
          n_fail++; $display("FAIL rand_byte%0d: got %h gid %0d expected %h gid %0d", k, out_q[k], out_g[k], exp_d[k], exp_g[k]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    m_ready = 1'b0;
    s_valid = '0;
    s_data = '0;
    s_last = '0;
    test_reset();
    test_basic();
    test_all_simul();
    test_mid_packet();
    test_stall();
    test_valid_gap();
    test_reset_mid();
    for (int r = 0; r < 4; r++) test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter among `N_REQ` byte-stream requesters. Each requester presents packets: byte streams terminated by a `last` flag. Once granted, a requester keeps the transmitter until its final byte is accepted, so packets never interleave on the serial line. The block sits between the per-channel packet producers and the single UART TX serializer, which consumes bytes over a valid/ready handshake.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, range 2..16.
- `BITS_PER_WORD`, default 8: data byte width. Must match the UART serializer.

Ports:
- `clk`, input, 1: the only clock.
- `rst`, input, 1: synchronous, active-high reset.
- `s_valid`, input, `N_REQ`: per-requester byte valid.
- `s_data`, input, `N_REQ`×`BITS_PER_WORD` (packed, requester i at `[i*BITS_PER_WORD +: BITS_PER_WORD]`): per-requester byte.
- `s_last`, input, `N_REQ`: marks the final byte of a packet.
- `s_ready`, output, `N_REQ`: byte accepted from requester i when `s_valid[i] && s_ready[i]`.
- `m_valid`, output, 1: byte offered to the UART serializer.
- `m_data`, output, `BITS_PER_WORD`: byte to serialize.
- `m_ready`, input, 1: serializer is accepting the byte.
- `busy`, output, 1: high whenever the state is not IDLE.
- `grant_id`, output, `$clog2(N_REQ)`: index of the current or most recent owner.

## Operation
- State machine states: IDLE, HDR, DATA. HDR exists only when `UART_ARB_ID_HDR_EN` is defined.
- **IDLE**
  - `m_valid=0`, all `s_ready=0`.
  - If any `s_valid` is high, round-robin selects the first requesting index, searching from `(last_grant+1) mod N_REQ` upward with wrap.
  - The selected index is registered into `grant_id` and `last_grant`.
  - Next state is HDR if enabled, otherwise DATA.
- **HDR**
  - `m_valid=1`, `m_data` = `grant_id` zero-extended to `BITS_PER_WORD`, all `s_ready=0`.
  - On `m_ready`, go to DATA.
- **DATA**
  - `m_valid = s_valid[grant_id]`, `m_data = s_data[grant_id]`.
  - `s_ready[grant_id] = m_ready`; all other `s_ready=0`. These are combinational pass-throughs.
  - On a transfer with `s_last[grant_id]=1`, go to IDLE.
- Transfers without `s_last` stay in DATA.
- Deasserting `s_valid` in DATA holds the grant indefinitely. There is no timeout.
- Requests from non-granted requesters are ignored until the state returns to IDLE. Those requesters see `s_ready=0`.
- If several requesters assert `s_valid` in the same cycle, the rotating priority picks one. No requester waits more than `N_REQ-1` packets.
- Inputs of non-granted requesters never affect `m_*`.

## Timing
- Reset values: state=IDLE, `last_grant=N_REQ-1` (requester 0 has top priority first), `grant_id=0`, `busy=0`, `m_valid=0`, `m_data=0`, `s_ready=0`.
- Reset asserted mid-packet:
  - Next cycle is IDLE and the partial packet is abandoned.
  - The requester must restart that packet.
  - The serializer may already hold the accepted byte.
- Arbitration latency: request seen in IDLE at cycle t, then first `m_valid` at t+1.
- Packet gap: after a `last` transfer at cycle t, the state is IDLE at t+1 and the next packet's first byte is at t+2. One idle bubble per packet is required.
- With `m_ready` held high, the DATA state moves one byte per cycle.
- `m_valid` never depends combinationally on `m_ready`.
- `m_data` holds stable while `m_valid && !m_ready`, provided the requester obeys the same rule.
- Single-byte packet (`s_last` on the first byte): DATA lasts one cycle when `m_ready=1`.

## Configuration
- Macro `UART_ARB_ID_HDR_EN`.
- When defined: HDR state compiled in. Each packet on the line is preceded by one header byte equal to the requester index. Header-to-first-data latency is one accepted transfer.
- When undefined: no HDR state. IDLE goes directly to DATA and the serial stream carries only payload bytes.

## Structure
- Shared package `uart_pkg`:
  - state enum `arb_state_t` (IDLE, HDR, DATA).
  - default `BITS_PER_WORD` constant.
  - function `rr_pick(req, last)` returning the next index.
- One sub-module, `rr_priority_sel`: combinational rotating-priority encoder (`req` vector and `last` index in, `gnt_idx` and `any` out). It is kept separate for reuse by other arbiters in the codebase.

## Test plan
- Reset, then requester 2 sends the 3-byte packet 0x41,0x42,0x43 with `m_ready=1`:
  - m_data sequence is 0x41,0x42,0x43 (preceded by 0x02 if `_EN`).
  - `grant_id=2`, `busy` drops one cycle after 0x43.
- All four requesters assert 1-byte packets simultaneously, held continuously: grants are 0,1,2,3,0 in order, one IDLE cycle between packets.
- Requester 1 is mid-packet (2 of 4 bytes sent) when requester 0 asserts: `s_ready[0]` stays 0 until requester 1's `last` byte transfers, then requester 0 is granted.
- `m_ready` toggled 1,0,0,1 during a packet from requester 3 with data 0x5A,0xA5:
  - `m_data` holds 0x5A through the stall.
  - No byte is dropped or duplicated.
- Requester 1 drops `s_valid` for 5 cycles mid-packet: grant is retained, `m_valid=0` for those cycles, and the packet completes afterwards.
- `rst` pulsed for one cycle during byte 2 of 4: next cycle is IDLE with all outputs at reset values, and requester 0 wins the following arbitration.
